// File: rtl/fsa_draw_sched.sv
// fsa_draw_sched: walks an alien formation, issuing one draw request per
// live alien to a downstream per-object draw FSA and waiting for its
// completion handshake before moving on.
// Optional feature: define SCHED_TIMEOUT_EN to abandon an alien after 15
// cycles without continue_draw and pulse draw_timeout.
module fsa_draw_sched #(
  parameter int COLS   = 8,
  parameter int ROWS   = 4,
  parameter int X_STEP = 6,
  parameter int Y_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [ROWS*COLS-1:0] alive_mask,
  input  logic [7:0]           base_x,
  input  logic [6:0]           base_y,
  input  logic                 continue_draw,
  output logic                 draw_enable,
  output logic [7:0]           x_pixel,
  output logic [6:0]           y_pixel,
  output logic [4:0]           alien_idx,
  output logic                 busy,
  output logic                 frame_done
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic                 draw_timeout
`endif
);

  localparam int         N    = ROWS * COLS;
  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mask_q;
  logic [7:0]     bx_q;
  logic [6:0]     by_q;
  logic [4:0]     idx_q;
  logic [7:0]     col_q;
  logic [6:0]     row_q;
  logic [7:0]     x_q;
  logic [6:0]     y_q;
  logic [4:0]     aidx_q;
  logic           start;
  logic           advance;
  logic           latch_pos;
  logic           ack;
  logic           timeout;
  logic [7:0]     x_calc;
  logic [6:0]     y_calc;

  // Pixel origin of the alien at the current scan position, wrapping naturally.
  assign x_calc = bx_q + col_q * 8'(X_STEP);
  assign y_calc = by_q + row_q * 7'(Y_STEP);

`ifdef SCHED_TIMEOUT_EN
  logic [3:0] to_cnt_q;

  // Watchdog counter: zero on WAIT_ACK entry, counts while waiting.
  always_ff @(posedge clk) begin
    if (reset)                   to_cnt_q <= 4'd0;
    else if (state_q == ISSUE)   to_cnt_q <= 4'd0;
    else if (state_q == WAIT_ACK) to_cnt_q <= to_cnt_q + 4'd1;
  end

  assign timeout      = (state_q == WAIT_ACK) && (to_cnt_q == 4'd15) && !continue_draw;
  assign draw_timeout = timeout && !reset;
`else
  assign timeout = 1'b0;
`endif

  // Next-state and control decode for the scan FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    start     = 1'b0;
    advance   = 1'b0;
    latch_pos = 1'b0;
    ack       = (state_q == WAIT_ACK) && (continue_draw || timeout);
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          start   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (mask_q[idx_q]) begin
          latch_pos = 1'b1;
          state_d   = ISSUE;
        end else if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (ack) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, scan position and presented draw coordinates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      col_q   <= 8'd0;
      row_q   <= 7'd0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      aidx_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q <= 5'd0;
        col_q <= 8'd0;
        row_q <= 7'd0;
      end else if (advance) begin
        idx_q <= idx_q + 5'd1;
        if (col_q == 8'(COLS - 1)) begin
          col_q <= 8'd0;
          row_q <= row_q + 7'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
      if (latch_pos) begin
        x_q    <= x_calc;
        y_q    <= y_calc;
        aidx_q <= idx_q;
      end
    end
  end

  // Snapshot of the pass inputs; only read after a capture, so no reset.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are deliberately left out of reset; they are always written before use.
    if (start) begin
      mask_q <= alive_mask;
      bx_q   <= base_x;
      by_q   <= base_y;
    end
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    draw_enable = (state_q == ISSUE) && !reset;
    busy        = (state_q != IDLE) && !reset;
    frame_done  = (state_q == DONE) && !reset;
    x_pixel     = reset ? 8'd0 : x_q;
    y_pixel     = reset ? 7'd0 : y_q;
    alien_idx   = reset ? 5'd0 : aidx_q;
  end

endmodule

// File: doc/fsa_draw_sched.md
FSA_DRAW_SCHED -- requirements
Module: fsa_draw_sched

Interface
REQ-001 Parameter COLS, default 8: alien columns in the formation.
REQ-002 Parameter ROWS, default 4: alien rows in the formation.
REQ-003 Parameter X_STEP, default 6: horizontal pixel pitch between columns.
REQ-004 Parameter Y_STEP, default 4: vertical pixel pitch between rows.
REQ-005 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frame_start  input  1  one-cycle request to begin a drawing pass.
REQ-008 alive_mask  input  ROWS*COLS  bit i=1 means alien i is alive; i = row*COLS + col.
REQ-009 base_x  input  8  formation origin x.
REQ-010 base_y  input  7  formation origin y.
REQ-011 continue_draw  input  1  completion handshake from the per-object draw FSA.
REQ-012 draw_enable  output  1  one-cycle start pulse to the per-object draw FSA.
REQ-013 x_pixel  output  8  x origin of the current alien.
REQ-014 y_pixel  output  7  y origin of the current alien.
REQ-015 alien_idx  output  5  index of the current alien.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at the end of a pass.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, ISSUE, WAIT_ACK and DONE.
REQ-019 In IDLE, frame_start=1 SHALL capture alive_mask, base_x and base_y into internal registers, clear idx to 0 and go to LOAD.
REQ-020 In LOAD, the block SHALL go to ISSUE if the captured bit idx is 1. Otherwise it SHALL go to DONE if idx=ROWS*COLS-1, else increment idx and stay in LOAD.
REQ-021 In ISSUE, draw_enable SHALL be 1 for exactly this cycle, and the next state SHALL be WAIT_ACK.
REQ-022 In WAIT_ACK, continue_draw=1 SHALL go to DONE if idx is last, else increment idx and go to LOAD. continue_draw=0 SHALL hold the state.
REQ-023 DONE SHALL assert frame_done for one cycle and then go to IDLE.
REQ-024 x_pixel SHALL equal base_x + (idx mod COLS)*X_STEP, truncated mod 256; y_pixel SHALL equal base_y + (idx div COLS)*Y_STEP, truncated mod 128; both SHALL use the captured base values.
REQ-025 x_pixel, y_pixel and alien_idx SHALL be registered and held stable from the ISSUE cycle through the cycle continue_draw is accepted.
REQ-026 continue_draw SHALL be ignored in every state except WAIT_ACK.
REQ-027 frame_start SHALL be ignored while busy=1; changes to alive_mask or base_x/base_y mid-pass SHALL NOT affect the pass.
REQ-028 Latency: with alien 0 alive, frame_start at cycle 0 SHALL produce draw_enable at cycle 2.
REQ-029 With an all-zero mask, frame_done SHALL pulse ROWS*COLS+1 cycles after frame_start and draw_enable SHALL never assert.
REQ-030 frame_start and continue_draw in the same cycle while in IDLE SHALL start a pass; the stray continue_draw SHALL be dropped.

Reset
REQ-031 reset=1 SHALL force the state to IDLE and idx to 0, and SHALL override all other inputs, including mid-pass and in WAIT_ACK.
REQ-032 While reset=1 and on the first cycle after reset, draw_enable, busy, frame_done, x_pixel, y_pixel and alien_idx SHALL all be 0.

Configuration
REQ-033 With macro SCHED_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to WAIT_ACK and increment each cycle in that state. At count 15 without continue_draw, the block SHALL abandon the alien exactly as if continue_draw had been accepted, and SHALL pulse an additional output draw_timeout (1 bit) for one cycle.
REQ-034 With SCHED_TIMEOUT_EN undefined, draw_timeout SHALL not exist and WAIT_ACK SHALL wait indefinitely.

Verification
REQ-035 Reset during WAIT_ACK at idx=5 -> next cycle busy=0, alien_idx=0, draw_enable=0; a later continue_draw has no effect.
REQ-036 Mask=all ones, base_x=10, base_y=20, continue_draw returned 5 cycles after each draw_enable -> 32 draw_enable pulses; at idx=9, x_pixel=16 and y_pixel=24; exactly one frame_done.
REQ-037 Mask=0x00000001, frame_start -> draw_enable at cycle 2; continue_draw at cycle 7 -> frame_done pulses after LOAD scans idx 1..31.
REQ-038 base_x=250, idx=3 (col 3) -> x_pixel=12 (wrap); base_y=126, idx=8 (row 1) -> y_pixel=2.
REQ-039 frame_start pulsed again mid-pass, with alive_mask changed to 0 mid-pass -> pass continues using the captured mask; no restart.
REQ-040 SCHED_TIMEOUT_EN defined, continue_draw withheld for alien 0 -> draw_timeout pulses 15 cycles after WAIT_ACK entry, and the pass proceeds to alien 1.
